// File: rtl/mem_seq.sv
// mem_seq: sequences fetch and data-port word accesses onto an asynchronous
// 16-bit SRAM. Round-robin arbitration, IDLE -> SETUP -> ACCESS -> DONE, with
// every SRAM control, ack and read-data output driven straight from a flop.
module mem_seq #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        if_req,
  input  logic [19:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [19:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ack,
  output logic        busy,
  output logic [19:0] ADDR,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  inout  wire  [15:0] Data
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  // Counter value that marks the final strobe-active cycle.
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_data_q, last_data_d;   // 1: data port was granted last
  logic        gnt_data_q, gnt_data_d;     // 1: in-flight access belongs to data port
  logic        we_lat_q, we_lat_d;
  logic [15:0] wdata_q, wdata_d;
  logic [19:0] addr_q, addr_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        drive_q, drive_d;
  logic        busy_q, busy_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        grant_data;

  // Next-state, arbitration, request latching and read-data capture.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch to hold it.
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_data_d = last_data_q;
    gnt_data_d  = gnt_data_q;
    we_lat_d    = we_lat_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_data  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // A lone requester wins; on a tie the port not served last wins.
          grant_data  = d_req && (!if_req || !last_data_q);
          gnt_data_d  = grant_data;
          last_data_d = grant_data;
          we_lat_d    = grant_data && d_we;
          wdata_d     = d_wdata;
          addr_d      = grant_data ? d_addr : if_addr;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = DONE;
          // The edge leaving the last strobe cycle is where SRAM data is valid.
          if (!gnt_data_q) begin
            if_rdata_d = Data;
          end else if (!we_lat_q) begin
            d_rdata_d = Data;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the pins come straight off flops.
  always_comb begin
    ce_n_d   = (state_d == IDLE);
    oe_n_d   = !((state_d == ACCESS) && !we_lat_d);
    we_n_d   = !((state_d == ACCESS) && we_lat_d);
    drive_d  = we_lat_d && ((state_d == ACCESS) || (state_d == DONE));
    busy_d   = (state_d != IDLE);
    if_ack_d = (state_d == DONE) && !gnt_data_d;
    d_ack_d  = (state_d == DONE) && gnt_data_d;
  end

  // State and output registers; reset parks the SRAM bus idle and released.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_data_q <= 1'b1;
      gnt_data_q  <= 1'b0;
      we_lat_q    <= 1'b0;
      wdata_q     <= '0;
      addr_q      <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      drive_q     <= 1'b0;
      busy_q      <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_data_q <= last_data_d;
      gnt_data_q  <= gnt_data_d;
      we_lat_q    <= we_lat_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      drive_q     <= drive_d;
      busy_q      <= busy_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign ADDR     = addr_q;
  assign CE       = ce_n_q;
  assign UB       = ce_n_q;
  assign LB       = ce_n_q;
  assign OE       = oe_n_q;
  assign WE       = we_n_q;
  assign busy     = busy_q;
  assign if_ack   = if_ack_q;
  assign d_ack    = d_ack_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign Data     = drive_q ? wdata_q : 16'bz;

endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: directed vector table, multi-cycle corner sequences and a
// randomized run against a transaction-level model of the sequencer.
module tb_mem_seq;

  localparam int W = 2;

  logic        Clk, Reset;
  logic        if_req, d_req, d_we;
  logic [19:0] if_addr, d_addr;
  logic [15:0] d_wdata;
  logic [15:0] if_rdata, d_rdata;
  logic        if_ack, d_ack, busy;
  logic [19:0] ADDR;
  logic        CE, UB, LB, OE, WE;
  wire  [15:0] data_bus;

  logic        rst1, if_req1;
  logic [15:0] if_rdata1, d_rdata1;
  logic        if_ack1, d_ack1, busy1;
  logic [19:0] ADDR1;
  logic        CE1, UB1, LB1, OE1, WE1;
  wire  [15:0] data_bus1;

  int    vectors, miscompares;
  string ctx;

  mem_seq #(.WAIT_CYCLES(W)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .busy(busy),
    .ADDR(ADDR), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .Data(data_bus)
  );

  mem_seq #(.WAIT_CYCLES(1)) u_dut1 (
    .Clk(Clk), .Reset(rst1),
    .if_req(if_req1), .if_addr(20'h00ABC), .if_rdata(if_rdata1), .if_ack(if_ack1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(20'h00000), .d_wdata(16'h0000),
    .d_rdata(d_rdata1), .d_ack(d_ack1), .busy(busy1),
    .ADDR(ADDR1), .CE(CE1), .UB(UB1), .LB(LB1), .OE(OE1), .WE(WE1), .Data(data_bus1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM power-up contents.
  function automatic logic [15:0] init_word(input logic [19:0] a);
    return (a == 20'h00010) ? 16'h1234 : (a[15:0] ^ 16'hA5A5);
  endfunction

  // Asynchronous SRAM model for the main instance.
  logic [15:0] sram [0:1048575];
  bit          sram_written [0:1048575];
  logic [15:0] sram_word;
  assign sram_word = sram_written[ADDR] ? sram[ADDR] : init_word(ADDR);
  assign data_bus  = (!CE && !OE && WE) ? sram_word : 16'bz;
  always @(posedge Clk) begin
    if (!CE && !WE) begin
      sram[ADDR]         <= data_bus;
      sram_written[ADDR] <= 1'b1;
    end
  end

  // Read-only SRAM for the one-wait-cycle instance.
  assign data_bus1 = (!CE1 && !OE1 && WE1) ? (ADDR1[15:0] ^ 16'h3C3C) : 16'bz;

  function automatic logic [15:0] sram_peek(input logic [19:0] a);
    return sram_written[a] ? sram[a] : init_word(a);
  endfunction

  logic [15:0] ref_mem [0:1048575];

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s/%s: got %0h expected %0h", ctx, name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_data;
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic        drop;       // release request one cycle after grant
    logic        scramble;   // disturb address/data inputs after grant
    logic [15:0] exp_rdata;
  } vec_t;

  // One isolated access starting with the DUT idle; checks every cycle's pins.
  task automatic run_vec(input vec_t v);
    logic rd, active, acc, done;
    rd = !(v.is_data && v.we);
    if (v.is_data) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    if (v.is_data && v.we) ref_mem[v.addr] = v.wdata;
    for (int c = 1; c <= W + 3; c++) begin
      @(negedge Clk);
      active = (c <= W + 2);
      acc    = (c >= 2) && (c <= W + 1);
      done   = (c == W + 2);
      check("busy", 20'(busy), 20'(active));
      check("CE", 20'(CE), 20'(!active));
      check("UB", 20'(UB), 20'(!active));
      check("LB", 20'(LB), 20'(!active));
      check("OE", 20'(OE), 20'(!(rd && acc)));
      check("WE", 20'(WE), 20'(!(!rd && acc)));
      check("if_ack", 20'(if_ack), 20'(done && !v.is_data));
      check("d_ack", 20'(d_ack), 20'(done && v.is_data));
      if (active) check("ADDR", ADDR, v.addr);
      if (!rd && c >= 2 && active) check("store Data", 20'(data_bus), 20'(v.wdata));
      if (done && rd) check("rdata", v.is_data ? 20'(d_rdata) : 20'(if_rdata), 20'(v.exp_rdata));
      if (c == 1 && v.scramble) begin
        if_addr = 20'h00FFF; d_addr = 20'h00FFF; d_wdata = ~v.wdata; d_we = ~v.we;
      end
      if ((c == 1 && v.drop) || done) begin
        if_req = 1'b0; d_req = 1'b0;
      end
    end
  endtask

  function automatic logic [19:0] rnd_addr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) == 0) return r[19:0];
    return 20'($urandom_range(0, 15));
  endfunction

  // Randomized traffic vs. a transaction model: one access at a time, grant
  // in an idle cycle, ack W+2 cycles after grant, next grant one cycle later.
  task automatic run_random(input int n);
    bit          pend, pend_d, pend_we, last_d;
    int          grant_t, ack_t, free_t;
    logic [19:0] pend_addr;
    logic [15:0] exp_rd, exp_if_rd, exp_d_rd;
    pend = 1'b0; pend_d = 1'b0; pend_we = 1'b0; last_d = 1'b1;
    grant_t = 0; ack_t = 0; free_t = 0;
    pend_addr = '0; exp_rd = '0; exp_if_rd = '0; exp_d_rd = '0;
    ctx = "random";
    for (int t = 0; t < n; t++) begin
      if (t > 0) @(negedge Clk);
      if (pend && t == ack_t) begin
        if (!pend_d) exp_if_rd = exp_rd;
        else if (!pend_we) exp_d_rd = exp_rd;
      end
      check("if_ack", 20'(if_ack), 20'(pend && !pend_d && t == ack_t));
      check("d_ack", 20'(d_ack), 20'(pend && pend_d && t == ack_t));
      check("busy", 20'(busy), 20'(pend && t > grant_t));
      if (pend && t > grant_t) check("ADDR", ADDR, pend_addr);
      check("if_rdata", 20'(if_rdata), 20'(exp_if_rd));
      check("d_rdata", 20'(d_rdata), 20'(exp_d_rd));
      if (pend && t == ack_t) begin
        pend   = 1'b0;
        free_t = t + 1;
        if (pend_d) d_req = 1'b0;
        else if_req = 1'b0;
      end
      // In-flight port: inputs wander, request sometimes released early.
      if (pend && pend_d) begin
        d_addr = rnd_addr(); d_wdata = 16'($urandom); d_we = 1'($urandom);
        if ($urandom_range(0, 7) == 0) d_req = 1'b0;
      end else if (pend) begin
        if_addr = rnd_addr();
        if ($urandom_range(0, 7) == 0) if_req = 1'b0;
      end
      if (t < n - 20) begin
        if (!if_req && !(pend && !pend_d) && $urandom_range(0, 1) == 1) begin
          if_req = 1'b1; if_addr = rnd_addr();
        end
        if (!d_req && !(pend && pend_d) && $urandom_range(0, 1) == 1) begin
          d_req = 1'b1; d_addr = rnd_addr(); d_we = 1'($urandom); d_wdata = 16'($urandom);
        end
      end
      if (!pend && t >= free_t && (if_req || d_req)) begin
        if (if_req && d_req) pend_d = !last_d;
        else pend_d = d_req;
        last_d  = pend_d;
        pend    = 1'b1;
        grant_t = t;
        ack_t   = t + W + 2;
        if (pend_d) begin
          pend_addr = d_addr; pend_we = d_we;
          if (d_we) ref_mem[d_addr] = d_wdata;
          else exp_rd = ref_mem[d_addr];
        end else begin
          pend_addr = if_addr; pend_we = 1'b0;
          exp_rd = ref_mem[if_addr];
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [10];
    logic [15:0] old_word;
    int          k;
    logic        is_ack;

    vectors = 0; miscompares = 0;
    Reset = 1'b1; rst1 = 1'b1; if_req1 = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 1048576; i++) ref_mem[i] = init_word(20'(i));

    tbl[0] = '{1'b0, 1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0, 16'h1234};
    tbl[1] = '{1'b1, 1'b1, 20'h00020, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
    tbl[2] = '{1'b1, 1'b0, 20'h00020, 16'h0000, 1'b0, 1'b0, 16'hBEEF};
    tbl[3] = '{1'b1, 1'b0, 20'h00020, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
    tbl[4] = '{1'b0, 1'b0, 20'hFFFFF, 16'h0000, 1'b0, 1'b0, 16'h5A5A};
    tbl[5] = '{1'b1, 1'b1, 20'hFFFFF, 16'h0F0F, 1'b1, 1'b0, 16'h0000};
    tbl[6] = '{1'b1, 1'b0, 20'hFFFFF, 16'h0000, 1'b1, 1'b0, 16'h0F0F};
    tbl[7] = '{1'b0, 1'b0, 20'h00000, 16'h0000, 1'b0, 1'b1, 16'hA5A5};
    tbl[8] = '{1'b1, 1'b1, 20'h00001, 16'h1357, 1'b0, 1'b1, 16'h0000};
    tbl[9] = '{1'b0, 1'b0, 20'h00001, 16'h0000, 1'b0, 1'b0, 16'h1357};

    // Reset state.
    ctx = "reset";
    @(negedge Clk);
    check("CE", 20'(CE), 20'h1);
    check("OE", 20'(OE), 20'h1);
    check("WE", 20'(WE), 20'h1);
    check("UB", 20'(UB), 20'h1);
    check("LB", 20'(LB), 20'h1);
    check("busy", 20'(busy), 20'h0);
    check("if_ack", 20'(if_ack), 20'h0);
    check("d_ack", 20'(d_ack), 20'h0);
    check("ADDR", ADDR, 20'h0);
    check("if_rdata", 20'(if_rdata), 20'h0);
    check("d_rdata", 20'(d_rdata), 20'h0);

    // Directed table.
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ctx = $sformatf("vec%0d", i);
      run_vec(tbl[i]);
    end

    // Both ports requesting continuously from reset: fetch, data, fetch, data.
    ctx = "tie";
    Reset = 1'b1;
    if_req = 1'b1; if_addr = 20'h00010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00020;
    @(negedge Clk);
    Reset = 1'b0;
    for (int c = 1; c <= 4 * (W + 3); c++) begin
      @(negedge Clk);
      is_ack = (c >= W + 2) && ((c - (W + 2)) % (W + 3) == 0);
      k = (c - (W + 2)) / (W + 3);
      check("if_ack", 20'(if_ack), 20'(is_ack && (k % 2 == 0)));
      check("d_ack", 20'(d_ack), 20'(is_ack && (k % 2 == 1)));
      if (is_ack && k % 2 == 0) check("if_rdata", 20'(if_rdata), 20'h01234);
      if (is_ack && k % 2 == 1) check("d_rdata", 20'(d_rdata), 20'h0BEEF);
      if (is_ack && k == 3) begin
        if_req = 1'b0; d_req = 1'b0;
      end
    end

    // Reset during the strobe of a store.
    ctx = "abort";
    old_word = sram_peek(20'h00030);
    d_req = 1'b1; d_we = 1'b1; d_addr = 20'h00030; d_wdata = 16'hCAFE;
    @(negedge Clk);
    @(negedge Clk);
    check("WE in ACCESS", 20'(WE), 20'h0);
    Reset = 1'b1;
    d_req = 1'b0;
    #1;
    check("WE", 20'(WE), 20'h1);
    check("CE", 20'(CE), 20'h1);
    check("OE", 20'(OE), 20'h1);
    check("busy", 20'(busy), 20'h0);
    check("d_ack", 20'(d_ack), 20'h0);
    check("ADDR", ADDR, 20'h0);
    check("if_rdata", 20'(if_rdata), 20'h0);
    check("d_rdata", 20'(d_rdata), 20'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      Reset = 1'b0;
      check("post d_ack", 20'(d_ack), 20'h0);
      check("post busy", 20'(busy), 20'h0);
    end
    check("memory", 20'(sram_peek(20'h00030) == old_word || sram_peek(20'h00030) == 16'hCAFE), 20'h1);
    ref_mem[20'h00030] = sram_peek(20'h00030);

    // Randomized traffic.
    run_random(600);

    // One wait cycle, fetch held high: ack every 4 cycles, one idle cycle between.
    ctx = "w1";
    @(negedge Clk);
    rst1 = 1'b0; if_req1 = 1'b1;
    check("busy", 20'(busy1), 20'h0);
    check("if_ack", 20'(if_ack1), 20'h0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      check("if_ack", 20'(if_ack1), 20'(c % 4 == 3));
      check("busy", 20'(busy1), 20'(c % 4 != 0));
      check("UB", 20'(UB1), 20'(c % 4 == 0));
      check("LB", 20'(LB1), 20'(c % 4 == 0));
      check("d_ack", 20'(d_ack1), 20'h0);
      check("d_rdata", 20'(d_rdata1), 20'h0);
      if (c % 4 == 3) check("if_rdata", 20'(if_rdata1), 20'h03680);
    end
    if_req1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_seq.md
MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, SRAM strobe-active cycles per access (legal 1..15).
REQ-002 SHALL have port Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port if_req  input  1  instruction-fetch read request, held high until if_ack.
REQ-005 SHALL have port if_addr  input  20  fetch word address.
REQ-006 SHALL have port if_rdata  output  16  fetched word, valid while if_ack high.
REQ-007 SHALL have port if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port d_req  input  1  data load/store request, held high until d_ack.
REQ-009 SHALL have port d_we  input  1  1 = store, 0 = load; sampled at grant.
REQ-010 SHALL have port d_addr  input  20  data word address.
REQ-011 SHALL have port d_wdata  input  16  store data, sampled at grant.
REQ-012 SHALL have port d_rdata  output  16  loaded word, valid while d_ack high.
REQ-013 SHALL have port d_ack  output  1  one-cycle data completion pulse.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have ports ADDR  output  20, CE, UB, LB, OE, WE  output  1 each, active-low SRAM controls.
REQ-016 SHALL have port Data  inout  16  shared SRAM data bus.

Function
REQ-017 SHALL implement states IDLE, SETUP, ACCESS, DONE; all outputs registered.
REQ-018 IDLE: if any request high, grant per REQ-019, latch address/we/wdata, go to SETUP; else stay.
REQ-019 Arbitration round-robin: only one requester -> it wins; both -> port not granted last wins; last-granted = data after reset, so fetch wins first tie.
REQ-020 SETUP (1 cycle): ADDR = latched address, CE=0, OE=1, WE=1, Data high-Z.
REQ-021 ACCESS (exactly WAIT_CYCLES cycles, counter-driven): CE=0; read -> OE=0, WE=1, Data high-Z; write -> OE=1, WE=0, Data driven with latched wdata.
REQ-022 Read data SHALL be captured from Data on the clock edge ending the last ACCESS cycle.
REQ-023 DONE (1 cycle): CE=0, OE=1, WE=1; write data still driven (hold); granted port ack=1 with rdata valid; next state IDLE.
REQ-024 Latency: request seen in IDLE at cycle 0 -> ack high in cycle WAIT_CYCLES+2; per-access throughput WAIT_CYCLES+3 cycles.
REQ-025 UB=0, LB=0 whenever CE=0; UB=LB=1 in IDLE.
REQ-026 Data SHALL be high-Z in IDLE, SETUP and all read cycles; never driven while OE=0.
REQ-027 Request dropped before ack: access SHALL complete, ack still pulses; no abort.
REQ-028 if_ack and d_ack SHALL never be high in the same cycle; each high only in DONE.
REQ-029 Address/wdata changes after grant SHALL NOT affect the in-flight access.
REQ-030 if_rdata/d_rdata SHALL hold last captured value between accesses.

Reset
REQ-031 Reset high SHALL immediately force IDLE, CE=OE=WE=UB=LB=1, Data high-Z, ADDR=0, acks=0, busy=0, rdata=0, counter=0, last-granted=data.
REQ-032 Reset mid-access SHALL abandon the access without ack; first edge after release samples requests in IDLE.

Verification
REQ-033 Fetch read, WAIT_CYCLES=2, if_addr=0x00010, SRAM word 0x1234 -> OE low cycles 2-3, if_ack cycle 4, if_rdata=0x1234.
REQ-034 Store d_we=1, d_addr=0x00020, d_wdata=0xBEEF -> WE low 2 cycles, Data=0xBEEF cycles 2-4, readback load returns 0xBEEF.
REQ-035 if_req and d_req both high from reset -> fetch acked first, data next; repeated ties alternate.
REQ-036 Reset asserted in ACCESS of a store -> WE/CE high and Data high-Z same cycle, no d_ack, memory unchanged or partial only.
REQ-037 d_addr changed to 0x00FFF during SETUP of load at 0x00020 -> ADDR stays 0x00020 through DONE.
REQ-038 WAIT_CYCLES=1 back-to-back fetches -> ack every 4 cycles, busy low exactly one cycle between.
